// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - sequential line-memory reader streaming words through a 2-entry skid FIFO
module bram_stream_reader #(
    parameter int RAM_WIDTH  = 13,
    parameter int NB_ADDRESS = 10
) (
    input  logic                  i_CLK,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [NB_ADDRESS-1:0] i_baseAdd,
    input  logic [NB_ADDRESS:0]   i_length,
    output logic [NB_ADDRESS-1:0] o_readAdd,
    input  logic [RAM_WIDTH-1:0]  i_memData,
    output logic [RAM_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [NB_ADDRESS-1:0] ADDR_ONE = 1;
    localparam logic [NB_ADDRESS:0]   CNT_ONE  = 1;

    state_t                 state;
    state_t                 state_next;
    logic [NB_ADDRESS-1:0]  addr_cnt;
    logic [NB_ADDRESS-1:0]  last_add;
    logic [NB_ADDRESS:0]    issue_cnt;
    logic [NB_ADDRESS:0]    remain_cnt;
    logic                   inflight;
    logic [RAM_WIDTH-1:0]   fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             fifo_count;
    logic                   pop;
    logic                   push;
    logic                   issue;
    logic                   accept;
    logic                   done_next;
    logic                   done_q;
    logic [2:0]             occ_next;

    assign o_valid  = (fifo_count != 2'd0);
    assign o_data   = fifo_mem[rd_ptr];
    assign pop      = o_valid && i_ready;
    assign push     = inflight;
    assign o_busy   = (state != IDLE);
    assign o_done   = done_q;

    // Occupancy the FIFO will have once this cycle's pop and pending capture settle;
    // issuing only while it is below 2 leaves room for the word this issue brings back.
    assign occ_next = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    // The memory samples the address every cycle; when idle it keeps seeing the last one.
    assign o_readAdd = issue ? addr_cnt : last_add;

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        accept     = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_length != '0) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        done_next  = 1'b1;
                    end
                end
            end
            RUN: begin
                issue = (issue_cnt != '0) && (occ_next < 3'd2);
                if ((issue_cnt == '0) || (issue && (issue_cnt == CNT_ONE))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((remain_cnt == '0) || (pop && (remain_cnt == CNT_ONE))) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            addr_cnt    <= '0;
            last_add    <= '0;
            issue_cnt   <= '0;
            remain_cnt  <= '0;
            inflight    <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q   <= done_next;
            inflight <= issue;
            last_add <= o_readAdd;

            if (accept) begin
                addr_cnt   <= i_baseAdd;
                issue_cnt  <= i_length;
                remain_cnt <= i_length;
            end else begin
                if (issue) begin
                    addr_cnt  <= addr_cnt + ADDR_ONE;
                    issue_cnt <= issue_cnt - CNT_ONE;
                end
                if (pop && (remain_cnt != '0)) begin
                    remain_cnt <= remain_cnt - CNT_ONE;
                end
            end

            if (push) begin
                fifo_mem[wr_ptr] <= i_memData;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed and randomized checks of bram_stream_reader against a memory model
module tb_bram_stream_reader;

    logic        i_CLK = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [9:0]  i_baseAdd;
    logic [10:0] i_length;
    logic [9:0]  o_readAdd;
    logic [12:0] i_memData;
    logic [12:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_done;

    logic [12:0] mem [1024];
    int          n_pass = 0;
    int          n_total = 0;

    bram_stream_reader #(.RAM_WIDTH(13), .NB_ADDRESS(10)) dut (
        .i_CLK     (i_CLK),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_baseAdd (i_baseAdd),
        .i_length  (i_length),
        .o_readAdd (o_readAdd),
        .i_memData (i_memData),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 i_CLK = ~i_CLK;

    // Memory with registered read port: data for the sampled address appears next cycle.
    always @(posedge i_CLK) i_memData <= mem[o_readAdd];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // mode 0: ready held high (exact cycle timing checked); 1: ready 1,0,0 repeating; 2: random ready.
    task automatic do_xfer(input int base, input int len, input int mode, input bit inject);
        int          exp_q[$];
        int          got;
        int          dones;
        int          done_cyc;
        int          first_valid;
        bit          prev_stall;
        logic [12:0] prev_data;
        for (int i = 0; i < len; i++) exp_q.push_back(int'(mem[(base + i) % 1024]));
        got = 0; dones = 0; done_cyc = -1; first_valid = -1; prev_stall = 0; prev_data = '0;
        @(posedge i_CLK); #1;
        i_start   = 1'b1;
        i_baseAdd = 10'(base);
        i_length  = 11'(len);
        for (int c = 0; c < len * 4 + 20; c++) begin
            if (c > 0) begin
                @(posedge i_CLK); #1;
                i_start = inject && (c == 2);
                if (inject && c == 2) begin
                    i_baseAdd = 10'd500;
                    i_length  = 11'd7;
                end
            end
            i_ready = ready_for(mode, c);
            @(negedge i_CLK);
            if (prev_stall) begin
                check("stall_valid", 32'(o_valid), 32'd1);
                check("stall_data", 32'(o_data), 32'(prev_data));
            end
            if (mode == 0) begin
                check("busy", 32'(o_busy), 32'(len > 0 && c >= 1 && c <= len + 2));
                if (c >= 1 && c <= len) check("read_addr", 32'(o_readAdd), 32'((base + c - 1) % 1024));
            end
            if (o_valid && first_valid < 0) first_valid = c;
            if (o_valid && i_ready) begin
                if (got < len) check("data", 32'(o_data), 32'(exp_q[got]));
                got++;
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            if (o_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        check("word_count", 32'(got), 32'(len));
        check("done_count", 32'(dones), 32'd1);
        if (mode == 0) begin
            check("first_valid_cycle", 32'(first_valid), (len == 0) ? 32'hFFFF_FFFF : 32'd3);
            check("done_cycle", 32'(done_cyc), (len == 0) ? 32'd1 : 32'(len + 3));
        end
        i_start = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_baseAdd = '0; i_length = '0; i_ready = 1'b1;
        for (int a = 0; a < 1024; a++) mem[a] = 13'(a);
        repeat (3) @(posedge i_CLK);
        #1 i_reset = 1'b0;
        @(negedge i_CLK);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_addr", 32'(o_readAdd), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);

        do_xfer(0, 4, 0, 1'b0);
        do_xfer(1022, 4, 0, 1'b0);
        do_xfer(10, 6, 1, 1'b0);
        do_xfer(0, 0, 0, 1'b0);
        do_xfer(20, 8, 0, 1'b1);
        do_xfer(0, 1024, 0, 1'b0);

        // Reset in the cycle after the third address is issued.
        @(posedge i_CLK); #1;
        i_start = 1'b1; i_baseAdd = 10'd0; i_length = 11'd10; i_ready = 1'b1;
        @(posedge i_CLK); #1 i_start = 1'b0;
        @(posedge i_CLK); #1;
        @(posedge i_CLK); #1;
        @(posedge i_CLK); #1 i_reset = 1'b1;
        @(posedge i_CLK); #1 i_reset = 1'b0;
        @(negedge i_CLK);
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_done", 32'(o_done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_CLK);
            check("post_rst_done", 32'(o_done), 32'd0);
            check("post_rst_valid", 32'(o_valid), 32'd0);
        end
        do_xfer(100, 2, 0, 1'b0);

        for (int a = 0; a < 1024; a++) mem[a] = 13'($urandom);
        for (int t = 0; t < 12; t++) begin
            do_xfer(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)),
                    int'($urandom_range(0, 2)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side controller for the simple dual-port line memory (registered read data, 1-cycle read latency).
- On a start command, it issues sequential read addresses from a base address for a given word count. It streams the returned words out on a valid/ready interface towards the convolution datapath.
- It absorbs the memory's read latency and downstream backpressure with a 2-entry skid FIFO, so no word is lost or duplicated.

Parameters:
- RAM_WIDTH, 13, data word width in bits (matches memory word).
- NB_ADDRESS, 10, address width; memory depth 2**NB_ADDRESS.

Ports:
- i_CLK  input  1  system clock, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  start-transfer pulse; sampled only in IDLE.
- i_baseAdd  input  NB_ADDRESS  first read address, captured on accepted i_start.
- i_length  input  NB_ADDRESS+1  number of words, 0..2**NB_ADDRESS, captured on accepted i_start.
- o_readAdd  output  NB_ADDRESS  read address to the memory read port.
- i_memData  input  RAM_WIDTH  memory registered read data, valid 1 cycle after address is sampled.
- o_data  output  RAM_WIDTH  stream data (FIFO head).
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts; a transfer occurs when o_valid && i_ready.
- o_busy  output  1  transfer in progress.
- o_done  output  1  one-cycle pulse at transfer end.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - State goes to IDLE; outputs become o_valid=0, o_busy=0, o_done=0, o_readAdd=0, o_data=0.
  - FIFO is emptied and the issue/remaining counters and in-flight flag are cleared.
  - Reset applied mid-transfer aborts the transfer. Memory data returning on the next cycle must not be captured. No o_done is generated.
- States: IDLE, RUN, DRAIN.
  - IDLE: i_start=1 with i_length!=0 captures the base address into the address counter and the length into the issue and remaining counters, then goes to RUN. i_start with i_length==0 stays in IDLE and pulses o_done on the next cycle.
  - RUN: issue reads. When the issue counter reaches 0, go to DRAIN.
  - DRAIN: wait until the remaining counter is 0, i.e. the last word has been accepted downstream. Then go to IDLE and pulse o_done for that one cycle.
  - i_start is ignored outside IDLE.
- o_busy=1 in RUN and DRAIN.
- Issue rule (RUN):
  - A read is issued in a cycle when issue>0 and (fifo_count − pop + inflight) < 2, where pop = o_valid && i_ready and inflight means a read was issued in the previous cycle.
  - On issue: o_readAdd holds the current address counter value; the counter then increments and issue decrements.
  - The address counter wraps modulo 2**NB_ADDRESS, so base 1020 with length 8 reads 1020..1023, 0..3.
- Capture: if inflight=1, i_memData is written into the FIFO at the end of that cycle. The occupancy bound guarantees the FIFO never overflows.
- Output:
  - o_valid = (fifo_count != 0); o_data = FIFO head. Words leave in address order.
  - Each transfer decrements the remaining counter. Push and pop in the same cycle keep the count unchanged.
- Latency: i_start accepted in cycle 0 → first address on o_readAdd in cycle 1 → i_memData in cycle 2 → o_valid=1 in cycle 3.
- Throughput: with i_ready held at 1, one word per cycle is sustained.
- Backpressure: with i_ready=0, at most 2 words are buffered and issuing stalls. Data is held stable while o_valid=1 && i_ready=0.
- When no read is issued, o_readAdd holds its last value.

Test Plan:
- Basic: memory preloaded with word[a]=a. base=0, length=4, i_ready=1 → o_data 0,1,2,3 in consecutive cycles 3..6; o_done pulse in cycle 7; o_busy high for cycles 1..6.
- Wrap: base=1022, length=4 → o_data 1022,1023,0,1; o_readAdd sequence 1022,1023,0,1.
- Backpressure: base=10, length=6, i_ready toggling 1,0,0,1,... → each word 10..15 transferred exactly once in order. o_data stays stable while stalled. FIFO count never exceeds 2.
- Zero length and busy start: i_start with length=0 → no o_valid, o_done pulse next cycle. A second i_start during RUN with base=500 → ignored, original sequence completes unchanged.
- Full depth: base=0, length=1024, i_ready=1 → 1024 words 0..1023, then one o_done pulse.
- Reset mid-transfer: i_reset=1 in the cycle after the third address is issued → next cycle o_valid=0, o_busy=0, no o_done. A following transfer with base=100, length=2 outputs exactly 100,101 with no stale word.
